uart_rx_fifo: RTL and testbench

Receive buffer directly downstream of the UART receiver. Captures each one-cycle receive strobe (data byte plus break flag) into a DEPTH-entry circular FIFO. Presents the oldest entry to the host/bus side on a show-ahead valid/ready interface. Reports fill level, almost-full and a sticky overflow error for bytes lost while full.

---
 rtl/uart_rx_fifo_if.sv | 29 ++
 rtl/uart_rx_fifo.sv | 79 +++++++
 tb/tb_uart_rx_fifo.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/uart_rx_fifo_if.sv
// Handshake bundle between the UART receiver, the receive FIFO and the host side.
// The master modport is the environment; the slave modport is the FIFO itself.
interface uart_rx_fifo_if #(
    parameter int PAYLOAD_BITS = 8,
    parameter int DEPTH        = 16
);
    logic [PAYLOAD_BITS-1:0]    wr_data;
    logic                       wr_valid;
    logic                       wr_break;
    logic [PAYLOAD_BITS-1:0]    rd_data;
    logic                       rd_break;
    logic                       rd_valid;
    logic                       rd_ready;
    logic [$clog2(DEPTH):0]     level;
    logic                       almost_full;
    logic                       overflow;
    logic                       clr_overflow;
    logic                       flush;

    modport master (
        output wr_data, wr_valid, wr_break, rd_ready, clr_overflow, flush,
        input  rd_data, rd_break, rd_valid, level, almost_full, overflow
    );

    modport slave (
        input  wr_data, wr_valid, wr_break, rd_ready, clr_overflow, flush,
        output rd_data, rd_break, rd_valid, level, almost_full, overflow
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind the UART receiver: stores {break, data} per strobe and
// presents the oldest entry show-ahead, with level, almost-full and sticky overflow.
module uart_rx_fifo #(
    parameter int PAYLOAD_BITS = 8,
    parameter int DEPTH        = 16,
    parameter int AFULL_LEVEL  = 12
) (
    input  logic           clk,
    input  logic           resetn,
    uart_rx_fifo_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [PAYLOAD_BITS:0]   mem [DEPTH];
    logic [PTR_W-1:0]        wr_ptr_reg;
    logic [PTR_W-1:0]        rd_ptr_reg;
    logic [LVL_W-1:0]        level_reg;
    logic                    overflow_reg;

    logic                    rd_valid;
    logic                    full;
    logic                    pop;
    logic                    push;
    logic                    drop;
    logic [PAYLOAD_BITS:0]   head;

    assign rd_valid = (level_reg != '0);
    assign full     = (level_reg == LVL_W'(DEPTH));

    // Flush swallows any same-cycle read or write, so neither moves a pointer
    // nor counts as a dropped byte.
    assign pop  = rd_valid && bus.rd_ready && !bus.flush;
    assign push = bus.wr_valid && (!full || pop) && !bus.flush;
    assign drop = bus.wr_valid && full && !pop && !bus.flush;

    // Storage is left unreset; the read side is gated by rd_valid instead.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr_reg] <= {bus.wr_break, bus.wr_data};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            level_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (bus.flush) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
                level_reg  <= '0;
            end else begin
                if (push)
                    wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
                if (pop)
                    rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
                if (push && !pop)
                    level_reg <= level_reg + LVL_W'(1);
                else if (pop && !push)
                    level_reg <= level_reg - LVL_W'(1);
            end
            // A drop in the same cycle as a clear leaves the flag set.
            if (drop)
                overflow_reg <= 1'b1;
            else if (bus.clr_overflow)
                overflow_reg <= 1'b0;
        end
    end

    assign head            = mem[rd_ptr_reg];
    assign bus.rd_valid    = rd_valid;
    assign bus.rd_data     = rd_valid ? head[PAYLOAD_BITS-1:0] : '0;
    assign bus.rd_break    = rd_valid ? head[PAYLOAD_BITS] : 1'b0;
    assign bus.level       = level_reg;
    assign bus.almost_full = (level_reg >= LVL_W'(AFULL_LEVEL));
    assign bus.overflow    = overflow_reg;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo (DEPTH=16, AFULL_LEVEL=12); inputs change and
// outputs are sampled 1 ns after the rising edge.
module tb_uart_rx_fifo;
    logic clk;
    logic resetn;
    int   n_cmp;
    int   n_fail;

    uart_rx_fifo_if #(.PAYLOAD_BITS(8), .DEPTH(16)) bus ();

    uart_rx_fifo #(.PAYLOAD_BITS(8), .DEPTH(16), .AFULL_LEVEL(12)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [7:0] d, input logic b);
        bus.wr_data  = d;
        bus.wr_break = b;
        bus.wr_valid = 1'b1;
        tick();
        bus.wr_valid = 1'b0;
        bus.wr_break = 1'b0;
    endtask

    task automatic pop_word();
        bus.rd_ready = 1'b1;
        tick();
        bus.rd_ready = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        bus.wr_data = 8'h00; bus.wr_valid = 1'b0; bus.wr_break = 1'b0;
        bus.rd_ready = 1'b0; bus.clr_overflow = 1'b0; bus.flush = 1'b0;
        tick(); tick();
        n_cmp++; if (bus.rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid got %b want 0", bus.rd_valid); end
        n_cmp++; if (bus.rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_rd_data got %h want 00", bus.rd_data); end
        n_cmp++; if (bus.level !== 5'd0) begin n_fail++; $display("FAIL reset_level got %0d want 0", bus.level); end
        n_cmp++; if (bus.almost_full !== 1'b0) begin n_fail++; $display("FAIL reset_afull got %b want 0", bus.almost_full); end
        n_cmp++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %b want 0", bus.overflow); end
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_single();
        write_word(8'hA5, 1'b0);
        n_cmp++; if (bus.rd_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %b want 1", bus.rd_valid); end
        n_cmp++; if (bus.rd_data !== 8'hA5) begin n_fail++; $display("FAIL single_data got %h want a5", bus.rd_data); end
        n_cmp++; if (bus.level !== 5'd1) begin n_fail++; $display("FAIL single_level got %0d want 1", bus.level); end
        pop_word();
        n_cmp++; if (bus.rd_valid !== 1'b0) begin n_fail++; $display("FAIL single_empty_valid got %b want 0", bus.rd_valid); end
        n_cmp++; if (bus.level !== 5'd0) begin n_fail++; $display("FAIL single_empty_level got %0d want 0", bus.level); end
        n_cmp++; if (bus.rd_data !== 8'h00) begin n_fail++; $display("FAIL single_empty_data got %h want 00", bus.rd_data); end
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 16; i++) begin
            write_word(8'(i), 1'b0);
            n_cmp++; if (bus.almost_full !== (i + 1 >= 12)) begin n_fail++; $display("FAIL fill_afull after %0d writes got %b want %b", i + 1, bus.almost_full, (i + 1 >= 12)); end
        end
        n_cmp++; if (bus.level !== 5'd16) begin n_fail++; $display("FAIL fill_level got %0d want 16", bus.level); end
        n_cmp++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL fill_no_ovf got %b want 0", bus.overflow); end
        write_word(8'hFF, 1'b0);
        n_cmp++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL drop_ovf got %b want 1", bus.overflow); end
        n_cmp++; if (bus.level !== 5'd16) begin n_fail++; $display("FAIL drop_level got %0d want 16", bus.level); end
        for (int i = 0; i < 16; i++) begin
            n_cmp++; if (bus.rd_data !== 8'(i) || bus.rd_valid !== 1'b1) begin n_fail++; $display("FAIL drain[%0d] got %h/%b want %h/1", i, bus.rd_data, bus.rd_valid, 8'(i)); end
            pop_word();
        end
        n_cmp++; if (bus.rd_valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty got %b want 0", bus.rd_valid); end
        bus.clr_overflow = 1'b1; tick(); bus.clr_overflow = 1'b0;
    endtask

    task automatic test_full_pop();
        for (int i = 0; i < 16; i++) write_word(8'(8'h20 + i), 1'b0);
        bus.wr_data = 8'h55; bus.wr_valid = 1'b1; bus.rd_ready = 1'b1;
        tick();
        bus.wr_valid = 1'b0; bus.rd_ready = 1'b0;
        n_cmp++; if (bus.level !== 5'd16) begin n_fail++; $display("FAIL fullpop_level got %0d want 16", bus.level); end
        n_cmp++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL fullpop_ovf got %b want 0", bus.overflow); end
        for (int i = 1; i < 16; i++) begin
            n_cmp++; if (bus.rd_data !== 8'(8'h20 + i)) begin n_fail++; $display("FAIL fullpop_drain[%0d] got %h want %h", i, bus.rd_data, 8'(8'h20 + i)); end
            pop_word();
        end
        n_cmp++; if (bus.rd_data !== 8'h55 || bus.level !== 5'd1) begin n_fail++; $display("FAIL fullpop_last got %h lvl %0d want 55 lvl 1", bus.rd_data, bus.level); end
        pop_word();
        n_cmp++; if (bus.rd_valid !== 1'b0) begin n_fail++; $display("FAIL fullpop_empty got %b want 0", bus.rd_valid); end
    endtask

    task automatic test_wrap();
        logic [7:0] prev;
        prev = 8'h01;
        write_word(prev, 1'b0);
        for (int i = 1; i < 40; i++) begin
            n_cmp++; if (bus.rd_data !== prev) begin n_fail++; $display("FAIL wrap_data[%0d] got %h want %h", i, bus.rd_data, prev); end
            bus.wr_data = 8'(i * 7 + 1); bus.wr_valid = 1'b1; bus.rd_ready = 1'b1;
            tick();
            bus.wr_valid = 1'b0; bus.rd_ready = 1'b0;
            prev = 8'(i * 7 + 1);
            n_cmp++; if (bus.level !== 5'd1) begin n_fail++; $display("FAIL wrap_level[%0d] got %0d want 1", i, bus.level); end
        end
        n_cmp++; if (bus.rd_data !== prev) begin n_fail++; $display("FAIL wrap_last got %h want %h", bus.rd_data, prev); end
        pop_word();
        n_cmp++; if (bus.rd_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_empty got %b want 0", bus.rd_valid); end
    endtask

    task automatic test_break();
        write_word(8'h11, 1'b0);
        write_word(8'h00, 1'b1);
        write_word(8'h22, 1'b0);
        n_cmp++; if (bus.rd_data !== 8'h11 || bus.rd_break !== 1'b0) begin n_fail++; $display("FAIL brk0 got %h/%b want 11/0", bus.rd_data, bus.rd_break); end
        pop_word();
        n_cmp++; if (bus.rd_data !== 8'h00 || bus.rd_break !== 1'b1) begin n_fail++; $display("FAIL brk1 got %h/%b want 00/1", bus.rd_data, bus.rd_break); end
        pop_word();
        n_cmp++; if (bus.rd_data !== 8'h22 || bus.rd_break !== 1'b0) begin n_fail++; $display("FAIL brk2 got %h/%b want 22/0", bus.rd_data, bus.rd_break); end
        pop_word();
        n_cmp++; if (bus.rd_break !== 1'b0 || bus.rd_valid !== 1'b0) begin n_fail++; $display("FAIL brk_empty got %b/%b want 0/0", bus.rd_break, bus.rd_valid); end
    endtask

    task automatic test_overflow_flush();
        for (int i = 0; i < 17; i++) write_word(8'(8'h40 + i), 1'b0);
        n_cmp++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set got %b want 1", bus.overflow); end
        bus.clr_overflow = 1'b1;
        write_word(8'h77, 1'b0);
        bus.clr_overflow = 1'b0;
        n_cmp++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set_wins got %b want 1", bus.overflow); end
        bus.flush = 1'b1;
        write_word(8'h78, 1'b0);
        bus.flush = 1'b0;
        n_cmp++; if (bus.level !== 5'd0 || bus.rd_valid !== 1'b0) begin n_fail++; $display("FAIL flush_full got lvl %0d valid %b want 0/0", bus.level, bus.rd_valid); end
        n_cmp++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL flush_keeps_ovf got %b want 1", bus.overflow); end
        bus.clr_overflow = 1'b1; tick(); bus.clr_overflow = 1'b0;
        n_cmp++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got %b want 0", bus.overflow); end
        for (int i = 0; i < 5; i++) write_word(8'(8'h60 + i), 1'b0);
        n_cmp++; if (bus.level !== 5'd5) begin n_fail++; $display("FAIL pre_flush_level got %0d want 5", bus.level); end
        bus.flush = 1'b1; bus.rd_ready = 1'b1;
        write_word(8'h99, 1'b0);
        bus.flush = 1'b0; bus.rd_ready = 1'b0;
        n_cmp++; if (bus.level !== 5'd0 || bus.rd_valid !== 1'b0 || bus.rd_data !== 8'h00) begin n_fail++; $display("FAIL flush5 got lvl %0d valid %b data %h want 0/0/00", bus.level, bus.rd_valid, bus.rd_data); end
        n_cmp++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL flush5_ovf got %b want 0", bus.overflow); end
        // Flush must have reset the pointers: the next word written is the next one read.
        write_word(8'h3C, 1'b0);
        n_cmp++; if (bus.rd_data !== 8'h3C || bus.level !== 5'd1) begin n_fail++; $display("FAIL post_flush got %h lvl %0d want 3c lvl 1", bus.rd_data, bus.level); end
        bus.wr_data = 8'hC3; bus.wr_valid = 1'b1;
        tick(); tick(); tick();
        #2 resetn = 1'b0;
        #1;
        n_cmp++; if (bus.rd_valid !== 1'b0 || bus.level !== 5'd0 || bus.rd_data !== 8'h00) begin n_fail++; $display("FAIL async_reset got valid %b lvl %0d data %h want 0/0/00", bus.rd_valid, bus.level, bus.rd_data); end
        n_cmp++; if (bus.almost_full !== 1'b0 || bus.overflow !== 1'b0 || bus.rd_break !== 1'b0) begin n_fail++; $display("FAIL async_reset_flags got af %b ovf %b brk %b want 0/0/0", bus.almost_full, bus.overflow, bus.rd_break); end
        bus.wr_valid = 1'b0;
        tick();
        resetn = 1'b1;
        tick();
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_single();
        test_fill_drain();
        test_full_pop();
        test_wrap();
        test_break();
        test_overflow_flush();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
